// File: rtl/dsm_fx.sv
// Fixed-point first/second-order delta-sigma modulator with saturating integrators,
// overload detection and an automatic flush/recovery sequence.
module dsm_fx #(
  parameter int DW        = 16,
  parameter int GUARD     = 4,
  parameter int FB_MAG    = 2**(DW-1)-1,
  parameter int OVL_LIM   = 8,
  parameter int FLUSH_LEN = 16,
  parameter int CW        = 8
) (
  input  logic                 clk,
  input  logic                 rstx,
  input  logic                 en,
  input  logic                 order_sel,
  input  logic signed [DW-1:0] data_in,
  input  logic                 ovl_clr,
  output logic                 data_out,
  output logic                 data_vld,
  output logic                 ovl,
  output logic [CW-1:0]        ovl_cnt
);
  localparam int IW  = DW + GUARD;
  localparam int SW  = IW + 2;
  localparam int SRW = $clog2(OVL_LIM + 1);
  localparam int FLW = $clog2(FLUSH_LEN + 1);

  localparam logic signed [IW-1:0] I_MAX = {1'b0, {(IW-1){1'b1}}};
  localparam logic signed [IW-1:0] I_MIN = -I_MAX;
  localparam logic signed [SW-1:0] W_MAX = {2'b00, I_MAX};
  localparam logic signed [SW-1:0] W_MIN = {2'b11, I_MIN};
  localparam logic signed [SW-1:0] W_FB  = SW'(FB_MAG);

  typedef enum logic {RUN, RECOVER} state_t;

  state_t                state_reg, state_next;
  logic signed [IW-1:0]  i1_reg, i1_next;
  logic signed [IW-1:0]  i2_reg, i2_next;
  logic [SRW-1:0]        sat_run_reg, sat_run_next;
  logic [FLW-1:0]        flush_reg, flush_next;
  logic                  toggle_reg, toggle_next;
  logic                  order_q_reg, order_q_next;
  logic                  vld_reg, vld_next;
  logic                  ovl_reg, ovl_next;
  logic [CW-1:0]         cnt_reg, cnt_next;

  logic signed [SW-1:0]  fb, din_x, i1_x, i2_x, i1_new_x, i1_sum, i2_sum;
  logic signed [IW-1:0]  i1_new, i2_new;
  logic                  sat_hit, order_chg, ovl_set;

  function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] v);
    if (v > W_MAX)
      return I_MAX;
    else if (v < W_MIN)
      return I_MIN;
    else
      return v[IW-1:0];
  endfunction

  // Feedback polarity follows the bit currently presented on data_out.
  assign fb       = data_out ? W_FB : -W_FB;
  assign din_x    = {{(SW-DW){data_in[DW-1]}}, data_in};
  assign i1_x     = {{2{i1_reg[IW-1]}}, i1_reg};
  assign i2_x     = {{2{i2_reg[IW-1]}}, i2_reg};
  assign i1_sum   = din_x - fb + i1_x;
  assign i1_new   = sat(i1_sum);
  assign i1_new_x = {{2{i1_new[IW-1]}}, i1_new};
  assign i2_sum   = i1_new_x - fb + i2_x;
  assign i2_new   = sat(i2_sum);

  assign sat_hit   = order_q_reg ? (i2_new == I_MAX || i2_new == I_MIN)
                                 : (i1_new == I_MAX || i1_new == I_MIN);
  assign order_chg = (order_sel != order_q_reg);

  assign data_out = (state_reg == RECOVER) ? toggle_reg
                  : (order_q_reg ? ~i2_reg[IW-1] : ~i1_reg[IW-1]);
  assign data_vld = vld_reg;
  assign ovl      = ovl_reg;
  assign ovl_cnt  = cnt_reg;

  always_comb begin
    state_next   = state_reg;
    i1_next      = i1_reg;
    i2_next      = i2_reg;
    sat_run_next = sat_run_reg;
    flush_next   = flush_reg;
    toggle_next  = toggle_reg;
    order_q_next = order_q_reg;
    cnt_next     = cnt_reg;
    vld_next     = en;
    ovl_set      = 1'b0;

    // An order switch discards loop history regardless of en.
    if (order_chg) begin
      order_q_next = order_sel;
      i1_next      = '0;
      i2_next      = '0;
      sat_run_next = '0;
    end

    if (en) begin
      case (state_reg)
        RUN: begin
          if (!order_chg) begin
            i1_next = i1_new;
            i2_next = order_q_reg ? i2_new : '0;
            if (!sat_hit)
              sat_run_next = '0;
            else if (sat_run_reg == SRW'(OVL_LIM - 1))
              ovl_set = 1'b1;
            else
              sat_run_next = sat_run_reg + SRW'(1);
          end
        end
        RECOVER: begin
          toggle_next = ~toggle_reg;
          i1_next     = '0;
          i2_next     = '0;
          if (flush_reg == FLW'(FLUSH_LEN - 1)) begin
            state_next = RUN;
            flush_next = '0;
          end else begin
            flush_next = flush_reg + FLW'(1);
          end
        end
        default: ;
      endcase
    end

    if (ovl_set) begin
      state_next   = RECOVER;
      i1_next      = '0;
      i2_next      = '0;
      sat_run_next = '0;
      flush_next   = '0;
      toggle_next  = 1'b1;
      if (cnt_reg != {CW{1'b1}})
        cnt_next = cnt_reg + CW'(1);
    end

    // A new overload wins over a simultaneous clear.
    ovl_next = ovl_set | (ovl_reg & ~ovl_clr);
  end

  always_ff @(posedge clk) begin
    if (!rstx) begin
      state_reg   <= RUN;
      i1_reg      <= '0;
      i2_reg      <= '0;
      sat_run_reg <= '0;
      flush_reg   <= '0;
      toggle_reg  <= 1'b1;
      order_q_reg <= order_sel;
      vld_reg     <= 1'b0;
      ovl_reg     <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      i1_reg      <= i1_next;
      i2_reg      <= i2_next;
      sat_run_reg <= sat_run_next;
      flush_reg   <= flush_next;
      toggle_reg  <= toggle_next;
      order_q_reg <= order_q_next;
      vld_reg     <= vld_next;
      ovl_reg     <= ovl_next;
      cnt_reg     <= cnt_next;
    end
  end
endmodule

// File: tb/tb_dsm_fx.sv
// Scoreboard bench for dsm_fx: two instances (default and small-overload parameters)
// share stimulus and are checked against a behavioural model on every data_vld pulse.
module tb_dsm_fx;
  logic               clk = 1'b0;
  logic               rstx = 1'b0;
  logic               en = 1'b0;
  logic               order_sel = 1'b1;
  logic signed [15:0] data_in = '0;
  logic               ovl_clr = 1'b0;
  logic               dout_a, vld_a, ovl_a;
  logic [7:0]         cnt_a;
  logic               dout_b, vld_b, ovl_b;
  logic [7:0]         cnt_b;

  always #5 clk = ~clk;

  dsm_fx u_a (
    .clk(clk), .rstx(rstx), .en(en), .order_sel(order_sel), .data_in(data_in),
    .ovl_clr(ovl_clr), .data_out(dout_a), .data_vld(vld_a), .ovl(ovl_a), .ovl_cnt(cnt_a)
  );

  dsm_fx #(.FB_MAG(16384), .OVL_LIM(4), .FLUSH_LEN(6)) u_b (
    .clk(clk), .rstx(rstx), .en(en), .order_sel(order_sel), .data_in(data_in),
    .ovl_clr(ovl_clr), .data_out(dout_b), .data_vld(vld_b), .ovl(ovl_b), .ovl_cnt(cnt_b)
  );

  typedef struct {
    longint i1, i2;
    int     sr, fl, cnt;
    bit     tg, rec, oq, ovl;
  } ms_t;

  typedef struct {
    longint fb, imax;
    int     lim, flen, cmax;
  } mp_t;

  ms_t ma, mb;
  mp_t pa, pb;
  int  q_a[$];
  int  q_b[$];
  int  checks = 0;
  int  errors = 0;
  int  ones_a = 0;
  int  vld_seen_a = 0;
  bit  i2_max_b = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint clamp(longint v, longint m);
    if (v > m) return m;
    if (v < -m) return -m;
    return v;
  endfunction

  function automatic bit mout(ms_t s);
    if (s.rec) return s.tg;
    return s.oq ? (s.i2 >= 0) : (s.i1 >= 0);
  endfunction

  function automatic ms_t mreset(bit osel);
    ms_t s;
    s.i1 = 0; s.i2 = 0; s.sr = 0; s.fl = 0; s.cnt = 0;
    s.tg = 1; s.rec = 0; s.oq = osel; s.ovl = 0;
    return s;
  endfunction

  // Reference behaviour of one clock edge, written from the modulator's description.
  function automatic ms_t mstep(ms_t s, mp_t p, bit e, bit osel, longint din, bit clr);
    ms_t    n;
    longint f, a1, a2, act;
    n = s;
    f = mout(s) ? p.fb : -p.fb;
    if (clr) n.ovl = 0;
    if (osel != s.oq) begin
      n.oq = osel; n.i1 = 0; n.i2 = 0; n.sr = 0;
    end
    if (e) begin
      if (s.rec) begin
        n.tg = !s.tg;
        n.fl = s.fl + 1;
        if (n.fl == p.flen) begin
          n.rec = 0; n.fl = 0;
        end
      end else if (osel == s.oq) begin
        a1 = clamp(din - f + s.i1, p.imax);
        a2 = s.oq ? clamp(a1 - f + s.i2, p.imax) : 0;
        n.i1 = a1; n.i2 = a2;
        act = s.oq ? a2 : a1;
        n.sr = (act == p.imax || act == -p.imax) ? s.sr + 1 : 0;
        if (n.sr == p.lim) begin
          n.rec = 1; n.ovl = 1; n.i1 = 0; n.i2 = 0; n.sr = 0; n.fl = 0; n.tg = 1;
          if (s.cnt < p.cmax) n.cnt = s.cnt + 1;
        end
      end
    end
    return n;
  endfunction

  function automatic int pack(ms_t s);
    return (int'(mout(s)) << 9) | (int'(s.ovl) << 8) | (s.cnt & 255);
  endfunction

  task automatic drive(input bit r, input bit e, input bit os, input int din, input bit clr);
    rstx = r; en = e; order_sel = os; data_in = 16'(din); ovl_clr = clr;
    if (!r) begin
      ma = mreset(os);
      mb = mreset(os);
    end else begin
      ma = mstep(ma, pa, e, os, din, clr);
      mb = mstep(mb, pb, e, os, din, clr);
      if (e) begin
        q_a.push_back(pack(ma));
        q_b.push_back(pack(mb));
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (vld_a) begin
      vld_seen_a++;
      ones_a += int'(dout_a);
      if (q_a.size() == 0) check_val("sb_a_extra_vld", 1, 0);
      else check_val("sb_a", {dout_a, ovl_a, cnt_a}, q_a.pop_front());
    end
    if (vld_b) begin
      if (q_b.size() == 0) check_val("sb_b_extra_vld", 1, 0);
      else check_val("sb_b", {dout_b, ovl_b, cnt_b}, q_b.pop_front());
    end
    if (u_b.i2_reg == 20'sd524287) i2_max_b = 1;
  end

  initial begin
    bit [5:0] seq;
    bit       hit;
    ms_t      trial;
    pa.fb = 32767; pa.imax = 524287; pa.lim = 8; pa.flen = 16; pa.cmax = 255;
    pb.fb = 16384; pb.imax = 524287; pb.lim = 4; pb.flen = 6;  pb.cmax = 255;
    ma = mreset(1'b1);
    mb = mreset(1'b1);

    drive(0, 0, 1, 0, 0);
    check_val("rst_dout_a", dout_a, 1); check_val("rst_vld_a", vld_a, 0);
    check_val("rst_ovl_a", ovl_a, 0);   check_val("rst_cnt_a", cnt_a, 0);
    check_val("rst_dout_b", dout_b, 1); check_val("rst_vld_b", vld_b, 0);
    check_val("rst_ovl_b", ovl_b, 0);   check_val("rst_cnt_b", cnt_b, 0);

    ones_a = 0; vld_seen_a = 0;
    for (int i = 0; i < 1024; i++) drive(1, 1, 1, 0, 0);
    drive(1, 0, 1, 0, 0);
    check_val("t1_ones", ones_a, 512);
    check_val("t1_vld_count", vld_seen_a, 1024);
    $display("t1 zero-input order2: ones=%0d vld=%0d", ones_a, vld_seen_a);

    drive(0, 0, 1, 0, 0);
    vld_seen_a = 0;
    drive(1, 1, 1, 0, 0);
    drive(1, 0, 1, 0, 0); check_val("t4_hold1", dout_a, mout(ma));
    drive(1, 0, 1, 0, 0); check_val("t4_hold2", dout_a, mout(ma));
    drive(1, 1, 1, 0, 0);
    drive(1, 0, 1, 0, 0);
    check_val("t4_vld_pulses", vld_seen_a, 2);
    $display("t4 enable gating: vld pulses=%0d", vld_seen_a);

    drive(0, 0, 1, 0, 0);
    ones_a = 0;
    for (int i = 0; i < 4096; i++) drive(1, 1, 1, 16383, 0);
    drive(1, 0, 1, 16383, 0);
    check_val("t2_density_o2", (ones_a >= 3031 && ones_a <= 3113), 1);
    check_val("t2_ovl_o2", ovl_a, 0);
    $display("t2 order2 dc=16383: ones=%0d of 4096", ones_a);

    drive(1, 0, 0, 16383, 0);
    check_val("t5_flip_i1_a", u_a.i1_reg, 0); check_val("t5_flip_i2_a", u_a.i2_reg, 0);
    check_val("t5_flip_i1_b", u_b.i1_reg, 0); check_val("t5_flip_i2_b", u_b.i2_reg, 0);

    ones_a = 0;
    for (int i = 0; i < 4096; i++) drive(1, 1, 0, 16383, 0);
    drive(1, 0, 0, 16383, 0);
    check_val("t2_density_o1", (ones_a >= 3031 && ones_a <= 3113), 1);
    check_val("t2_ovl_o1", ovl_a, 0);
    $display("t2 order1 dc=16383: ones=%0d of 4096", ones_a);

    drive(0, 0, 1, 0, 0);
    i2_max_b = 0;
    for (int i = 0; i < 300; i++) begin
      drive(1, 1, 1, 32767, 0);
      if (ovl_b) break;
    end
    check_val("t3_ovl", ovl_b, 1);
    check_val("t3_cnt", cnt_b, 1);
    check_val("t3_i2_reached_max", i2_max_b, 1);
    for (int k = 0; k < 6; k++) begin
      seq[5-k] = dout_b;
      drive(1, 1, 1, 32767, 0);
    end
    check_val("t3_flush_seq", seq, 6'b101010);
    check_val("t3_run_dout", dout_b, 1);
    check_val("t3_run_i1", u_b.i1_reg, 0);
    $display("t3 overload recovery: seq=%b", seq);

    hit = 0;
    for (int i = 0; i < 300; i++) begin
      trial = mstep(mb, pb, 1, 1, 32767, 0);
      if (trial.cnt != mb.cnt) begin
        drive(1, 1, 1, 32767, 1);
        hit = 1;
        break;
      end
      drive(1, 1, 1, 32767, 0);
    end
    check_val("t5_second_ovl_reached", hit, 1);
    check_val("t5_set_wins", ovl_b, 1);
    check_val("t5_cnt2", cnt_b, 2);
    drive(1, 0, 1, 32767, 1);
    check_val("t5_clr", ovl_b, 0);
    check_val("t5_cnt_kept", cnt_b, 2);
    $display("t5 clear vs set: ovl=%0d cnt=%0d", ovl_b, cnt_b);

    drive(1, 1, 1, 32767, 0);
    drive(1, 1, 1, 32767, 0);
    drive(0, 1, 1, 32767, 0);
    check_val("t6_dout", dout_b, 1);  check_val("t6_vld", vld_b, 0);
    check_val("t6_ovl", ovl_b, 0);    check_val("t6_cnt", cnt_b, 0);
    check_val("t6_i1", u_b.i1_reg, 0); check_val("t6_i2", u_b.i2_reg, 0);
    $display("t6 reset during recover: dout=%0d cnt=%0d", dout_b, cnt_b);

    for (int i = 0; i < 15000; i++) begin
      if (cnt_b == 8'hFF) break;
      drive(1, 1, 1, 32767, 0);
    end
    for (int i = 0; i < 100; i++) drive(1, 1, 1, 32767, 0);
    check_val("cnt_saturates", cnt_b, 255);
    $display("counter saturation: cnt_b=%0d", cnt_b);

    drive(1, 0, 1, 0, 0);
    check_val("sb_a_drained", q_a.size(), 0);
    check_val("sb_b_drained", q_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dsm_fx.md
Name: dsm_fx

Overview:
- Fixed-point, parametrised successor to the team's real-valued second-order delta-sigma modulator.
- Accepts a signed DW-bit sample on every enabled cycle and emits a 1-bit density-modulated stream. Loop order (1 or 2) is selectable at run time.
- Integrators saturate rather than wrap. Sustained saturation is detected as overload and triggers an automatic flush/recovery sequence with a sticky flag and event counter.
- Sits between the sensor stimulus path and the 1-bit decimator input.

Parameters:
- DW, 16, input width (signed two's complement).
- GUARD, 4, integrator guard bits; integrator width IW = DW+GUARD.
- FB_MAG, 2**(DW-1)-1, feedback magnitude; fb = +FB_MAG when data_out=1, -FB_MAG when data_out=0.
- OVL_LIM, 8, consecutive saturated enabled cycles that declare overload (≥1).
- FLUSH_LEN, 16, enabled cycles spent in RECOVER (≥1).
- CW, 8, width of overload event counter.

Ports:
- clk  in  1  clock, rising edge.
- rstx  in  1  reset, synchronous, active-low.
- en  in  1  update enable (oversampling strobe).
- order_sel  in  1  0: first-order loop, 1: second-order loop.
- data_in  in  DW  signed input sample.
- ovl_clr  in  1  clears the sticky ovl flag.
- data_out  out  1  modulator bit.
- data_vld  out  1  one-cycle pulse per update.
- ovl  out  1  sticky overload flag.
- ovl_cnt  out  CW  overload event count, saturating at 2**CW-1.

Behaviour:
- Reset (rstx=0 at clk edge):
  - i1_reg=0, i2=0, sat_run=0, toggle=1, state=RUN, order_q=order_sel.
  - Outputs: data_out=1, data_vld=0, ovl=0, ovl_cnt=0.
- Arithmetic: all sums are signed, computed at IW+2 bits, then saturated to ±(2**(IW-1)-1) before register write. data_in is sign-extended.
- RUN, en=1, order_sel=1:
  - i1 = data_in - fb + i1_reg (comb, saturated).
  - i1_reg <= i1.
  - i2 <= sat(i1 - fb + i2).
  - data_out = (i2 < 0) ? 0 : 1, combinational from the i2 register.
- RUN, en=1, order_sel=0:
  - i1_reg <= i1; i2 held at 0.
  - data_out = (i1_reg < 0) ? 0 : 1.
- en=0: all state and outputs hold; data_vld=0.
- data_vld: registered. It is 1 in the cycle after every en=1 cycle, in both RUN and RECOVER.
- Saturation tracking (RUN only):
  - After an en=1 update, if the active last integrator (i2 for order 2, i1_reg for order 1) equals either limit, sat_run increments; otherwise sat_run=0.
  - When sat_run reaches OVL_LIM: state goes to RECOVER; ovl<=1; ovl_cnt increments (saturating); i1_reg, i2, sat_run <= 0; flush counter <= 0; toggle <= 1.
- RECOVER:
  - Integrators are forced to 0; data_in is ignored.
  - data_out = toggle; toggle inverts on each en=1 cycle, giving 1,0,1,0,…
  - After FLUSH_LEN enabled cycles, return to RUN with integrators 0.
- Order change: when order_sel != order_q on any cycle (en ignored), then on that edge:
  - i1_reg, i2, sat_run <= 0 and order_q <= order_sel.
  - The state machine is unaffected.
- ovl_clr: clears ovl. If an overload is declared on the same edge, set wins and ovl stays 1. ovl_cnt is cleared only by reset.
- Reset mid-RECOVER: returns immediately to the reset state.

Test Plan:
1. DW=16, order_sel=1, data_in=0, en=1 continuous from reset → data_out sequence 1,0,0,1 repeating; exactly 512 ones in 1024 cycles; data_vld=1 every cycle after the first.
2. order_sel=1, data_in=16383 held for 4096 cycles → ones density 0.75±0.01; ovl stays 0. Repeat with order_sel=0 → same density ±0.01.
3. FB_MAG=16384, OVL_LIM=4, FLUSH_LEN=6, data_in=32767 → i2 reaches +524287; after 4 saturated cycles ovl=1 and ovl_cnt=1; next 6 enabled cycles data_out=1,0,1,0,1,0 with i1_reg=i2=0; then RUN resumes.
4. en toggled 1,0,0,1 with data_in=0 → state/data_out frozen on en=0 cycles; data_vld pulses exactly twice.
5. Flip order_sel mid-stream with en=0 → i1_reg=i2=0 on the next edge; with ovl=1, assert ovl_clr on the same edge as a new overload → ovl stays 1 and ovl_cnt increments.
6. Assert rstx=0 during RECOVER → next cycle state=RUN, data_out=1, ovl=0, ovl_cnt=0, integrators 0.
